// File: rtl/cpu6502_timing_pkg.sv
// Shared constants for the 6502C T-state sequencer: T-state numbers, interrupt
// vectors, the forced BRK opcode and the interrupt-source encoding.
package cpu6502_timing_pkg;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;

    localparam logic [15:0] VEC_RES = 16'hFFFC;
    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    localparam logic [7:0] BRK_OPCODE = 8'h00;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_RES,
        SRC_NMI,
        SRC_IRQ
    } int_src_e;

    function automatic logic [15:0] vecFor(input int_src_e src);
        logic [15:0] v;
        case (src)
            SRC_RES: v = VEC_RES;
            SRC_NMI: v = VEC_NMI;
            default: v = VEC_IRQ;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/t_state_int_sequencer_if.sv
// Bus between random control / interrupt pins (master) and the T-state
// sequencer (slave).
interface t_state_int_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int T_MAX  = 7,
    parameter int IRQ_CH = 1
);
    localparam int TW = $clog2(T_MAX);

    logic              RDY;
    logic              rw_in;
    logic [DATA_W-1:0] extDataBus;
    logic              go_t0;
    logic              i_flag;
    logic [IRQ_CH-1:0] irq_mask;
    logic [IRQ_CH-1:0] IRQ_L;
    logic              NMI_L;

    logic [TW-1:0]     t_state;
    logic              SYNC;
    logic [DATA_W-1:0] ir_out;
    logic              int_active;
    logic [15:0]       vec_addr;
    logic              timing_err;

    modport master (
        output RDY, rw_in, extDataBus, go_t0, i_flag, irq_mask, IRQ_L, NMI_L,
        input  t_state, SYNC, ir_out, int_active, vec_addr, timing_err
    );

    modport slave (
        input  RDY, rw_in, extDataBus, go_t0, i_flag, irq_mask, IRQ_L, NMI_L,
        output t_state, SYNC, ir_out, int_active, vec_addr, timing_err
    );

endinterface

// File: rtl/nmi_edge_detect.sv
// NMI_L synchroniser followed by a falling-edge detector; a held-low line
// yields exactly one pulse.
module nmi_edge_detect #(
    parameter int NMI_SYNC = 2
) (
    input  logic clock,
    input  logic RES_L,
    input  logic i_nmi_l,
    output logic o_fall
);

    // r_shift[NMI_SYNC-1] is the synchronised level, r_shift[NMI_SYNC] its previous value
    logic [NMI_SYNC:0] r_shift;

    always_ff @(posedge clock or negedge RES_L) begin
        if (!RES_L) begin
            r_shift <= '1;
        end else begin
            r_shift <= {r_shift[NMI_SYNC-1:0], i_nmi_l};
        end
    end

    assign o_fall = r_shift[NMI_SYNC] & ~r_shift[NMI_SYNC-1];

endmodule

// File: rtl/t_state_int_sequencer.sv
// T-state timing generator, instruction register and RES/NMI/IRQ sequencing
// for the 6502C core; a taken interrupt replaces the fetched opcode with BRK.
module t_state_int_sequencer
    import cpu6502_timing_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int T_MAX    = 7,
    parameter int IRQ_CH   = 1,
    parameter int NMI_SYNC = 2
) (
    input  logic                    clock,
    input  logic                    RES_L,
    t_state_int_sequencer_if.slave  bus
);

    localparam int            TW     = $clog2(T_MAX);
    localparam logic [TW-1:0] T_LAST = TW'(T_MAX - 1);

    logic [TW-1:0]     r_t_state;
    logic              r_sync;
    logic [DATA_W-1:0] r_ir;
    logic              r_int_active;
    logic [15:0]       r_vec;
    logic              r_timing_err;
    logic              r_res_pend;
    logic              r_nmi_pend;
    logic              r_take;
    int_src_e          r_take_src;

    logic              w_advance;
    logic              w_nmi_fall;
    logic              w_irq_req;
    logic              w_overrun;
    logic [TW-1:0]     w_t_next;
    int_src_e          w_src;

    nmi_edge_detect #(
        .NMI_SYNC (NMI_SYNC)
    ) u_nmi_edge (
        .clock   (clock),
        .RES_L   (RES_L),
        .i_nmi_l (bus.NMI_L),
        .o_fall  (w_nmi_fall)
    );

    // Only read cycles wait on RDY; writes always complete
    assign w_advance = ~(bus.rw_in & ~bus.RDY);
    assign w_irq_req = (|(~bus.IRQ_L & bus.irq_mask)) & ~bus.i_flag;

    always_comb begin
        w_t_next  = r_t_state;
        w_overrun = 1'b0;
        if (w_advance) begin
            if (r_t_state == TW'(T1)) begin
                w_t_next = TW'(T2);
            end else if (r_t_state == TW'(T0)) begin
                w_t_next = TW'(T1);
            end else if (bus.go_t0) begin
                w_t_next = TW'(T0);
            end else if (r_t_state == T_LAST) begin
                w_t_next  = TW'(T0);
                w_overrun = 1'b1;
            end else begin
                w_t_next = r_t_state + TW'(1);
            end
        end
    end

    always_comb begin
        w_src = SRC_NONE;
        if (r_res_pend) begin
            w_src = SRC_RES;
        end else if (r_nmi_pend) begin
            w_src = SRC_NMI;
        end else if (w_irq_req) begin
            w_src = SRC_IRQ;
        end
    end

    // Reset leaves a RES take armed so the first T1 after release fetches BRK
    always_ff @(posedge clock or negedge RES_L) begin
        if (!RES_L) begin
            r_t_state    <= TW'(T1);
            r_sync       <= 1'b1;
            r_ir         <= '0;
            r_int_active <= 1'b0;
            r_vec        <= VEC_RES;
            r_timing_err <= 1'b0;
            r_res_pend   <= 1'b1;
            r_nmi_pend   <= 1'b0;
            r_take       <= 1'b1;
            r_take_src   <= SRC_RES;
        end else begin
            r_t_state <= w_t_next;
            r_sync    <= (w_t_next == TW'(T1));
            if (w_overrun) begin
                r_timing_err <= 1'b1;
            end
            if (w_advance && r_t_state == TW'(T1)) begin
                r_ir         <= r_take ? DATA_W'(BRK_OPCODE) : bus.extDataBus;
                r_int_active <= r_take;
                if (r_take && r_take_src == SRC_RES) begin
                    r_res_pend <= 1'b0;
                end
                if (r_take && r_take_src == SRC_NMI) begin
                    r_nmi_pend <= 1'b0;
                end
            end
            if (w_advance && r_t_state == TW'(T0)) begin
                r_take     <= (w_src != SRC_NONE);
                r_take_src <= w_src;
                if (w_src != SRC_NONE) begin
                    r_vec <= vecFor(w_src);
                end
            end
            // A fresh NMI edge wins over a same-cycle clear
            if (w_nmi_fall) begin
                r_nmi_pend <= 1'b1;
            end
        end
    end

    assign bus.t_state    = r_t_state;
    assign bus.SYNC       = r_sync;
    assign bus.ir_out     = r_ir;
    assign bus.int_active = r_int_active;
    assign bus.vec_addr   = r_vec;
    assign bus.timing_err = r_timing_err;

endmodule

// File: tb/tb_t_state_int_sequencer.sv
// Directed-vector bench for t_state_int_sequencer with hand-computed
// expectations for reset, stalls, interrupt priority, overrun and mid-cycle reset.
module tb_t_state_int_sequencer;

    logic clock;
    logic RES_L;
    int   checkCount;
    int   failCount;

    t_state_int_sequencer_if #(.DATA_W(8), .T_MAX(7), .IRQ_CH(1)) bus ();

    t_state_int_sequencer #(
        .DATA_W   (8),
        .T_MAX    (7),
        .IRQ_CH   (1),
        .NMI_SYNC (2)
    ) dut (
        .clock (clock),
        .RES_L (RES_L),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges; outputs are sampled 1 time unit after the last edge
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [31:0] expT);
        checkOutput({tag, ".t_state"}, 32'(bus.t_state), expT);
        checkOutput({tag, ".SYNC"}, 32'(bus.SYNC), (expT == 32'd1) ? 32'd1 : 32'd0);
    endtask

    // From T2: go_t0 for one cycle, then land in T1
    task automatic runToT1();
        bus.go_t0 = 1'b1;
        applyStimulus(1);
        bus.go_t0 = 1'b0;
        applyStimulus(1);
    endtask

    initial begin
        checkCount     = 0;
        failCount      = 0;
        RES_L          = 1'b0;
        bus.RDY        = 1'b1;
        bus.rw_in      = 1'b1;
        bus.extDataBus = 8'hEA;
        bus.go_t0      = 1'b0;
        bus.i_flag     = 1'b1;
        bus.irq_mask   = 1'b1;
        bus.IRQ_L      = 1'b1;
        bus.NMI_L      = 1'b1;
        applyStimulus(3);

        // Reset state
        checkState("rst", 32'd1);
        checkOutput("rst.ir_out", 32'(bus.ir_out), 32'h00);
        checkOutput("rst.int_active", 32'(bus.int_active), 32'd0);
        checkOutput("rst.vec_addr", 32'(bus.vec_addr), 32'hFFFC);
        checkOutput("rst.timing_err", 32'(bus.timing_err), 32'd0);

        // First instruction after reset is a forced BRK
        RES_L = 1'b1;
        applyStimulus(1);
        checkState("brk0", 32'd2);
        checkOutput("brk0.ir_out", 32'(bus.ir_out), 32'h00);
        checkOutput("brk0.int_active", 32'(bus.int_active), 32'd1);
        checkOutput("brk0.vec_addr", 32'(bus.vec_addr), 32'hFFFC);
        bus.go_t0 = 1'b1;
        applyStimulus(1);
        checkState("brk0.t0", 32'd0);
        bus.go_t0 = 1'b0;
        applyStimulus(1);
        checkState("nop.t1", 32'd1);
        applyStimulus(1);
        checkState("nop.t2", 32'd2);
        checkOutput("nop.ir_out", 32'(bus.ir_out), 32'hEA);
        checkOutput("nop.int_active", 32'(bus.int_active), 32'd0);
        checkOutput("nop.vec_held", 32'(bus.vec_addr), 32'hFFFC);

        // RDY stall during the T1 read
        runToT1();
        bus.RDY        = 1'b0;
        bus.extDataBus = 8'hA9;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkState("stall", 32'd1);
            checkOutput("stall.ir_out", 32'(bus.ir_out), 32'hEA);
        end
        bus.RDY = 1'b1;
        applyStimulus(1);
        checkState("stall.rel", 32'd2);
        checkOutput("stall.rel.ir_out", 32'(bus.ir_out), 32'hA9);

        // Write cycles ignore RDY
        applyStimulus(1);
        checkState("wr.t3", 32'd3);
        bus.RDY   = 1'b0;
        bus.rw_in = 1'b0;
        applyStimulus(1);
        checkState("wr.t4", 32'd4);
        bus.RDY   = 1'b1;
        bus.rw_in = 1'b1;
        runToT1();
        applyStimulus(1);
        checkOutput("wr.next.ir_out", 32'(bus.ir_out), 32'hA9);

        // NMI and IRQ together: NMI first, then IRQ
        bus.NMI_L      = 1'b0;
        bus.IRQ_L      = 1'b0;
        bus.i_flag     = 1'b0;
        bus.extDataBus = 8'h4C;
        applyStimulus(3);
        checkState("nmi.t5", 32'd5);
        runToT1();
        checkOutput("nmi.vec_addr", 32'(bus.vec_addr), 32'hFFFA);
        applyStimulus(1);
        checkOutput("nmi.ir_out", 32'(bus.ir_out), 32'h00);
        checkOutput("nmi.int_active", 32'(bus.int_active), 32'd1);
        runToT1();
        checkOutput("irq.vec_addr", 32'(bus.vec_addr), 32'hFFFE);
        applyStimulus(1);
        checkOutput("irq.ir_out", 32'(bus.ir_out), 32'h00);
        checkOutput("irq.int_active", 32'(bus.int_active), 32'd1);

        // IRQ masked by the I flag, then by the channel mask
        bus.i_flag = 1'b1;
        runToT1();
        applyStimulus(1);
        checkOutput("ifl.ir_out", 32'(bus.ir_out), 32'h4C);
        checkOutput("ifl.int_active", 32'(bus.int_active), 32'd0);
        checkOutput("ifl.vec_addr", 32'(bus.vec_addr), 32'hFFFE);
        bus.i_flag     = 1'b0;
        bus.irq_mask   = 1'b0;
        bus.extDataBus = 8'h60;
        runToT1();
        applyStimulus(1);
        checkOutput("msk.ir_out", 32'(bus.ir_out), 32'h60);
        checkOutput("msk.int_active", 32'(bus.int_active), 32'd0);
        bus.IRQ_L    = 1'b1;
        bus.NMI_L    = 1'b1;
        bus.irq_mask = 1'b1;

        // Runaway instruction: T2..T6 then forced T0 with sticky error
        for (int t = 3; t <= 6; t++) begin
            applyStimulus(1);
            checkState("ovr", 32'(t));
            checkOutput("ovr.timing_err", 32'(bus.timing_err), 32'd0);
        end
        applyStimulus(1);
        checkState("ovr.t0", 32'd0);
        checkOutput("ovr.err_set", 32'(bus.timing_err), 32'd1);
        applyStimulus(2);
        checkState("ovr.t2", 32'd2);
        checkOutput("ovr.err_sticky", 32'(bus.timing_err), 32'd1);
        checkOutput("ovr.ir_out", 32'(bus.ir_out), 32'h60);

        // Asynchronous reset in the middle of T4
        applyStimulus(2);
        checkState("mid.t4", 32'd4);
        #2;
        RES_L = 1'b0;
        #1;
        checkState("mid.rst", 32'd1);
        checkOutput("mid.ir_out", 32'(bus.ir_out), 32'h00);
        checkOutput("mid.vec_addr", 32'(bus.vec_addr), 32'hFFFC);
        checkOutput("mid.timing_err", 32'(bus.timing_err), 32'd0);
        applyStimulus(1);
        RES_L          = 1'b1;
        bus.extDataBus = 8'hEA;
        applyStimulus(1);
        checkState("mid.brk", 32'd2);
        checkOutput("mid.brk.ir_out", 32'(bus.ir_out), 32'h00);
        checkOutput("mid.brk.int_active", 32'(bus.int_active), 32'd1);
        checkOutput("mid.brk.vec_addr", 32'(bus.vec_addr), 32'hFFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
